// File: rtl/spi_als_pkg.sv
// Shared types and control-word field positions for the PMOD ALS SPI master.
`timescale 1ns/1ps

package spi_als_pkg;

    // Transaction engine states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        XFER   = 3'd2,
        NEXT   = 3'd3,
        HOLD   = 3'd4,
        WRBACK = 3'd5
    } state_e;

    // Control word layout.
    localparam int CTRL_SEND    = 0;
    localparam int CTRL_NTX_LSB = 4;
    localparam int CTRL_NTX_MSB = 12;
    localparam int CTRL_NRX_LSB = 16;
    localparam int CTRL_NRX_MSB = 25;

    localparam int NTX_W = CTRL_NTX_MSB - CTRL_NTX_LSB + 1;
    localparam int NRX_W = CTRL_NRX_MSB - CTRL_NRX_LSB + 1;

    // One byte on the wire is eight SCLK periods, i.e. sixteen half-periods.
    localparam int HALF_PERIODS = 16;

    // Completion word: keep every bit of the latched control word, clear
    // send so the burst cannot retrigger, and report the transfer count.
    function automatic logic [31:0] writeback_word(input logic [31:0]      shadow,
                                                   input logic [NTX_W-1:0] n_tx_end);
        logic [31:0]      word;
        logic [NRX_W-1:0] n_rx;
        n_rx = NRX_W'(n_tx_end) + NRX_W'(1);
        word = shadow;
        word[CTRL_SEND] = 1'b0;
        word[CTRL_NRX_MSB:CTRL_NRX_LSB] = n_rx;
        return word;
    endfunction

endpackage

// File: rtl/module_spi_shift8.sv
// 8-bit SPI mode-0 data path: TX byte shifted out MSB first on falling
// SCLK strobes, RX byte assembled MSB first on rising SCLK strobes.
`timescale 1ns/1ps

module module_spi_shift8 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       sample,
    input  logic       shift,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] rx
);

    logic [7:0] tx_q;

    // TX shifter: zero-fill so the line returns low once the byte is out.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_q <= 8'h00;
        end else if (load) begin
            tx_q <= load_data;
        end else if (shift) begin
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    // RX shifter: each rising-edge sample enters at bit 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx <= 8'h00;
        end else if (sample) begin
            rx <= {rx[6:0], miso};
        end
    end

    assign mosi = tx_q[7];

endmodule

// File: rtl/module_spi_master_als.sv
// SPI master burst engine for the PMOD ALS path. Triggered by the send bit
// of the control word, it runs n_tx_end+1 contiguous byte transfers with CS
// held low, exchanges each byte in place in the data buffer and finally
// writes the updated control word back through the register's SPI port.
`timescale 1ns/1ps

module module_spi_master_als
    import spi_als_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int ADDR_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       ctrl_i,
    output logic              ctrl_wr_o,
    output logic [31:0]       ctrl_data_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    input  logic [31:0]       buf_rdata_i,
    output logic              buf_wr_o,
    output logic [31:0]       buf_wdata_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_HALF  = 4'(HALF_PERIODS - 1);

    state_e            state_q;
    logic [7:0]        tick_cnt_q;
    logic [3:0]        half_cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       shadow_q;
    logic [NTX_W-1:0]  n_tx_end_q;
    logic              load_pend_q;
    logic [1:0]        miso_sync_q;
    logic              sclk_q;
    logic              cs_n_q;
    logic              ctrl_wr_q;
    logic [31:0]       ctrl_data_q;
    logic              buf_wr_q;
    logic [31:0]       buf_wdata_q;

    logic              tick;
    logic              last_half;
    logic              last_byte;
    logic              sr_load;
    logic              sr_sample;
    logic              sr_shift;
    logic [7:0]        rx_byte;
    logic              sr_mosi;

    // Only the low byte of a buffer word is transmitted.
    logic              buf_rdata_unused;
    assign buf_rdata_unused = ^buf_rdata_i[31:8];

    // Two-flop synchroniser for the asynchronous slave data line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso_i};
        end
    end

    // Strobes for the byte shifter, derived from the divider and half-period count.
    // NOTE: every output of an always_comb is given a value on every path, so no latch is inferred.
    always_comb begin
        tick      = (tick_cnt_q == 8'd0);
        last_half = (half_cnt_q == LAST_HALF);
        last_byte = (idx_q == ADDR_W'(n_tx_end_q));
        sr_load   = load_pend_q && ((state_q == SETUP) || (state_q == XFER));
        sr_sample = 1'b0;
        sr_shift  = 1'b0;
        if (state_q == XFER && tick) begin
            sr_sample = ~half_cnt_q[0];
            sr_shift  =  half_cnt_q[0];
        end
    end

    module_spi_shift8 u_shift8 (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load      (sr_load),
        .load_data (buf_rdata_i[7:0]),
        .sample    (sr_sample),
        .shift     (sr_shift),
        .miso      (miso_sync_q[1]),
        .mosi      (sr_mosi),
        .rx        (rx_byte)
    );

    // Burst sequencer, inline SCLK divider and registered SPI/buffer/register outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            tick_cnt_q  <= 8'd0;
            half_cnt_q  <= 4'd0;
            idx_q       <= '0;
            shadow_q    <= 32'd0;
            n_tx_end_q  <= '0;
            load_pend_q <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            ctrl_wr_q   <= 1'b0;
            ctrl_data_q <= 32'd0;
            buf_wr_q    <= 1'b0;
            buf_wdata_q <= 32'd0;
        end else begin
            // Write strobes are single-cycle pulses unless re-asserted below.
            buf_wr_q  <= 1'b0;
            ctrl_wr_q <= 1'b0;
            if (sr_load) begin
                load_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // ctrl_i is only sampled here, so edits during a burst are ignored.
                    if (ctrl_i[CTRL_SEND]) begin
                        shadow_q    <= ctrl_i;
                        n_tx_end_q  <= ctrl_i[CTRL_NTX_MSB:CTRL_NTX_LSB];
                        idx_q       <= '0;
                        tick_cnt_q  <= DIV_RELOAD;
                        half_cnt_q  <= 4'd0;
                        load_pend_q <= 1'b1;
                        sclk_q      <= 1'b0;
                        cs_n_q      <= 1'b0;
                        state_q     <= SETUP;
                    end
                end

                SETUP: begin
                    // CS setup time before the first rising edge.
                    if (tick) begin
                        tick_cnt_q <= DIV_RELOAD;
                        half_cnt_q <= 4'd0;
                        state_q    <= XFER;
                    end else begin
                        tick_cnt_q <= tick_cnt_q - 8'd1;
                    end
                end

                XFER: begin
                    if (tick) begin
                        tick_cnt_q <= DIV_RELOAD;
                        half_cnt_q <= half_cnt_q + 4'd1;
                        sclk_q     <= ~half_cnt_q[0];
                        if (last_half) begin
                            buf_wr_q    <= 1'b1;
                            buf_wdata_q <= {24'd0, rx_byte};
                            state_q     <= last_byte ? HOLD : NEXT;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q - 8'd1;
                    end
                end

                NEXT: begin
                    // Advance to the next slot; its byte is loaded on the first
                    // XFER cycle, with CS still low so the frame stays contiguous.
                    idx_q       <= idx_q + ADDR_W'(1);
                    load_pend_q <= 1'b1;
                    tick_cnt_q  <= DIV_RELOAD;
                    state_q     <= XFER;
                end

                HOLD: begin
                    // CS hold time after the last falling edge.
                    if (tick) begin
                        cs_n_q      <= 1'b1;
                        ctrl_wr_q   <= 1'b1;
                        ctrl_data_q <= writeback_word(shadow_q, n_tx_end_q);
                        state_q     <= WRBACK;
                    end else begin
                        tick_cnt_q <= tick_cnt_q - 8'd1;
                    end
                end

                WRBACK: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign sclk_o      = sclk_q;
    assign cs_n_o      = cs_n_q;
    assign mosi_o      = sr_mosi;
    assign buf_addr_o  = idx_q;
    assign buf_wr_o    = buf_wr_q;
    assign buf_wdata_o = buf_wdata_q;
    assign ctrl_wr_o   = ctrl_wr_q;
    assign ctrl_data_o = ctrl_data_q;

endmodule

// File: tb/tb_module_spi_master_als.sv
// Directed bench for module_spi_master_als: a table of burst vectors plus
// hand-written sequences for reset, busy-ignore, idle and maximum burst.
`timescale 1ns/1ps

module tb_module_spi_master_als;

    localparam int ADDR_W = 9;

    typedef struct {
        logic [31:0] ctrl;     // control word written by the CPU
        int          nb;       // bytes in the burst
        logic [23:0] tx;       // TX bytes, byte 0 in [23:16]
        logic        loop;     // 1: miso = mosi, 0: slave model drives rx_exp
        logic [23:0] rx_exp;   // expected RX bytes, byte 0 in [23:16]
        logic [31:0] wb;       // expected write-back word
        int          cyc;      // expected busy cycles
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Instance 1 (CLK_DIV=5)
    logic [31:0]       ctrl_reg = 32'd0;
    logic [31:0]       ctrl_data;
    logic              ctrl_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_rdata;
    logic              buf_wr;
    logic [31:0]       buf_wdata;
    logic              busy, sclk, cs_n, mosi, miso;

    // Instance 2 (CLK_DIV=2)
    logic [31:0]       ctrl_reg2 = 32'd0;
    logic [31:0]       ctrl_data2;
    logic              ctrl_wr2;
    logic [ADDR_W-1:0] buf_addr2;
    logic [31:0]       buf_rdata2;
    logic              buf_wr2;
    logic [31:0]       buf_wdata2;
    logic              busy2, sclk2, cs_n2, mosi2;
    logic              miso2 = 1'b1;

    logic        ext_wr   = 1'b0;
    logic [31:0] ext_data = 32'd0;
    logic        ext_wr2  = 1'b0;
    logic [31:0] ext_data2 = 32'd0;

    logic [31:0] mem [0:511];
    logic        loopback  = 1'b1;
    logic [23:0] slave_pat = 24'd0;
    int          slave_idx = 0;
    logic        slave_bit;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    int busy_cyc = 0, cs_low_cyc = 0, wb_cnt = 0;
    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic mosi_q[$];
    int busy2_cyc = 0, wr2_n = 0, wr2_bad = 0, wr2_exp = 0, wr2_last = -1;

    always #50 clk = ~clk;

    module_spi_master_als #(.CLK_DIV(5), .ADDR_W(ADDR_W)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_reg), .ctrl_wr_o(ctrl_wr),
        .ctrl_data_o(ctrl_data), .buf_addr_o(buf_addr), .buf_rdata_i(buf_rdata),
        .buf_wr_o(buf_wr), .buf_wdata_o(buf_wdata), .busy_o(busy), .sclk_o(sclk),
        .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso)
    );

    module_spi_master_als #(.CLK_DIV(2), .ADDR_W(ADDR_W)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl_reg2), .ctrl_wr_o(ctrl_wr2),
        .ctrl_data_o(ctrl_data2), .buf_addr_o(buf_addr2), .buf_rdata_i(buf_rdata2),
        .buf_wr_o(buf_wr2), .buf_wdata_o(buf_wdata2), .busy_o(busy2), .sclk_o(sclk2),
        .cs_n_o(cs_n2), .mosi_o(mosi2), .miso_i(miso2)
    );

    // Control register models: the SPI write port wins over a CPU write.
    always @(posedge clk) begin
        if (ctrl_wr) ctrl_reg <= ctrl_data;
        else if (ext_wr) ctrl_reg <= ext_data;
        if (ctrl_wr2) ctrl_reg2 <= ctrl_data2;
        else if (ext_wr2) ctrl_reg2 <= ext_data2;
    end

    assign buf_rdata  = mem[buf_addr];
    assign buf_rdata2 = {23'd0, buf_addr2} ^ 32'h5A;

    // Mode-0 slave: presents its MSB when idle, advances after each falling SCLK.
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) slave_idx = 0;
        else      slave_idx = slave_idx + 1;
    end
    assign slave_bit = (slave_idx < 24) ? slave_pat[23 - slave_idx] : 1'b0;
    assign miso      = loopback ? mosi : slave_bit;

    always @(posedge sclk) mosi_q.push_back(mosi);

    always @(negedge clk) begin
        if (busy)  busy_cyc++;
        if (!cs_n) cs_low_cyc++;
        if (ctrl_wr) wb_cnt++;
        if (buf_wr) begin
            wr_addr_q.push_back(int'(buf_addr));
            wr_data_q.push_back(buf_wdata);
        end
        if (busy2) busy2_cyc++;
        if (buf_wr2) begin
            if (int'(buf_addr2) != wr2_exp || buf_wdata2 != 32'h0000_00FF) wr2_bad++;
            wr2_exp++;
            wr2_n++;
            wr2_last = int'(buf_addr2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] data);
        @(negedge clk);
        ext_data = data;
        ext_wr   = 1'b1;
        @(negedge clk);
        ext_wr   = 1'b0;
    endtask

    // Wait for the selected instance to become busy and return to idle.
    task automatic wait_idle(input string tag, input bit second, input int limit);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (second ? busy2 : busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int b_busy, b_cs, b_wb, b_q, b_m, bad;
        logic [23:0] got_tx, got_rx;
        logic [31:0] w;
        for (int i = 0; i < 3; i++) mem[i] = {24'hDEADBE, v.tx[23 - 8*i -: 8]};
        loopback  = v.loop;
        slave_pat = v.rx_exp;
        b_busy = busy_cyc; b_cs = cs_low_cyc; b_wb = wb_cnt;
        b_q = wr_addr_q.size(); b_m = mosi_q.size();
        cpu_write(v.ctrl);
        wait_idle(tag, 1'b0, 2000);
        check({tag, "_busy_cycles"}, busy_cyc - b_busy, v.cyc);
        check({tag, "_cs_low_cycles"}, cs_low_cyc - b_cs, v.cyc - 1);
        check({tag, "_sclk_rises"}, mosi_q.size() - b_m, 8 * v.nb);
        check({tag, "_buf_writes"}, wr_addr_q.size() - b_q, v.nb);
        check({tag, "_ctrl_wr_pulses"}, wb_cnt - b_wb, 1);
        check({tag, "_writeback"}, ctrl_reg, v.wb);
        got_tx = '0;
        for (int k = 0; k < 8 * v.nb && b_m + k < mosi_q.size(); k++) got_tx[23 - k] = mosi_q[b_m + k];
        check({tag, "_mosi_bits"}, 32'(got_tx), 32'(v.tx));
        got_rx = '0;
        bad = 0;
        for (int b = 0; b < v.nb && b_q + b < wr_addr_q.size(); b++) begin
            w = wr_data_q[b_q + b];
            if (wr_addr_q[b_q + b] != b) bad++;
            if (w[31:8] != 24'd0) bad++;
            got_rx[23 - 8*b -: 8] = w[7:0];
        end
        check({tag, "_rx_bytes"}, 32'(got_rx), 32'(v.rx_exp));
        check({tag, "_write_addr_fmt_errs"}, bad, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int b_busy, b_wb, b_q;
        vecs[0] = '{32'h0000_0001, 1, 24'hA5_00_00, 1'b1, 24'hA5_00_00, 32'h0001_0000, 91};
        vecs[1] = '{32'h0000_0011, 2, 24'h3C_C3_00, 1'b0, 24'h0F_F0_00, 32'h0002_0010, 172};
        vecs[2] = '{32'hFC00_E00F, 1, 24'h5A_00_00, 1'b1, 24'h5A_00_00, 32'hFC01_E00E, 91};
        vecs[3] = '{32'h0000_0021, 3, 24'h81_7E_55, 1'b1, 24'h81_7E_55, 32'h0003_0020, 253};
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        check("rst_ctrl_data", ctrl_data, 32'd0);
        check("rst_buf_wr", 32'(buf_wr), 32'd0);
        check("rst_buf_wdata", buf_wdata, 32'd0);
        check("rst_buf_addr", 32'(buf_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven bursts
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            repeat (3) @(negedge clk);
        end

        // send=0 at IDLE: nothing happens
        b_busy = busy_cyc; b_q = wr_addr_q.size();
        cpu_write(32'h0000_0FF0);
        repeat (30) @(negedge clk);
        check("nosend_busy_cycles", busy_cyc - b_busy, 0);
        check("nosend_buf_writes", wr_addr_q.size() - b_q, 0);
        check("nosend_cs_n", 32'(cs_n), 32'd1);

        // ctrl_i change during a burst is ignored
        mem[0] = {24'hDEADBE, 8'hC3};
        loopback = 1'b1;
        b_busy = busy_cyc; b_q = wr_addr_q.size(); b_wb = wb_cnt;
        cpu_write(32'h0000_0001);
        repeat (20) @(negedge clk);
        cpu_write(32'h0000_0051);
        wait_idle("ignore", 1'b0, 2000);
        check("ignore_buf_writes", wr_addr_q.size() - b_q, 1);
        check("ignore_writeback", ctrl_reg, 32'h0001_0000);
        check("ignore_busy_cycles", busy_cyc - b_busy, 91);
        if (wr_addr_q.size() > b_q) check("ignore_rx_data", wr_data_q[b_q], 32'h0000_00C3);
        repeat (30) @(negedge clk);
        check("ignore_no_retrigger", busy_cyc - b_busy, 91);
        check("ignore_ctrl_wr_pulses", wb_cnt - b_wb, 1);

        // Asynchronous reset mid-burst, at XFER cycle 40 (SCLK high)
        mem[0] = {24'hDEADBE, 8'hFF};
        b_q = wr_addr_q.size(); b_wb = wb_cnt;
        cpu_write(32'h0000_0001);
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("midrst_started", 32'(busy), 32'd1);
        repeat (44) @(negedge clk);
        check("midrst_pre_sclk", 32'(sclk), 32'd1);
        check("midrst_pre_cs_n", 32'(cs_n), 32'd0);
        #10 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        cpu_write(32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        b_busy = busy_cyc;
        repeat (20) @(negedge clk);
        check("midrst_no_writeback", wb_cnt - b_wb, 0);
        check("midrst_no_buf_write", wr_addr_q.size() - b_q, 0);
        check("midrst_stays_idle", busy_cyc - b_busy, 0);

        // Maximum burst on the CLK_DIV=2 instance
        b_busy = busy2_cyc;
        @(negedge clk);
        ext_data2 = 32'h0000_1FF1;
        ext_wr2   = 1'b1;
        @(negedge clk);
        ext_wr2   = 1'b0;
        wait_idle("maxburst", 1'b1, 20000);
        check("maxburst_buf_writes", wr2_n, 512);
        check("maxburst_addr_data_errs", wr2_bad, 0);
        check("maxburst_last_addr", wr2_last, 511);
        check("maxburst_writeback", ctrl_reg2, 32'h0200_1FF0);
        check("maxburst_busy_cycles", busy2_cyc - b_busy, 16900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_spi_master_als.md
Name: module_spi_master_als

Overview:
SPI master transaction engine for the PMOD ALS path, placed directly downstream of the SPI control register. It watches the control word and, when the send bit is set, runs a burst of N byte transfers (SPI mode 0) with CS held low. It shifts TX bytes out of the shared data buffer and writes each RX byte back to the same buffer slot. On completion it writes the updated control word back through the register's SPI write port (wr2/data2).

Parameters:
CLK_DIV, 5, SCLK half-period in clk_i cycles (10 MHz clock, 1 MHz SCLK); legal range 2..255
ADDR_W, 9, data buffer address width (512 byte slots)

Ports:
clk_i  in  1  system clock, 10 MHz
rst_n_i  in  1  asynchronous, active-low reset
ctrl_i  in  32  control word from register data_o
ctrl_wr_o  out  1  one-cycle write enable to register wr2_i
ctrl_data_o  out  32  write-back word to register data2_i
buf_addr_o  out  ADDR_W  data buffer address (asynchronous-read buffer)
buf_rdata_i  in  32  buffer read data; bits [7:0] are the TX byte
buf_wr_o  out  1  buffer write enable, one-cycle pulse per received byte
buf_wdata_o  out  32  {24'b0, rx_byte}
busy_o  out  1  high in every state except IDLE
sclk_o  out  1  SPI clock, CPOL=0
cs_n_o  out  1  chip select, active low
mosi_o  out  1  serial out, MSB first
miso_i  in  1  serial in; synchronised with 2 flops before use

Behaviour:
- Control fields: [0] send; [12:4] n_tx_end (bytes-1); [25:16] n_rx (transfers completed). All other bits are passed through unchanged on write-back.
- Reset (asynchronous, takes effect immediately, including mid-burst): state=IDLE, sclk_o=0, cs_n_o=1, mosi_o=0, ctrl_wr_o=0, ctrl_data_o=0, buf_wr_o=0, buf_wdata_o=0, buf_addr_o=0, busy_o=0, all counters 0.
- The half-period tick counter is loaded with CLK_DIV-1 at each state or half-period boundary. The tick fires when it reaches 0.
- IDLE: when ctrl_i[0]=1:
  - latch ctrl_i into a shadow register and latch n_tx_end;
  - set idx=0, buf_addr_o=0;
  - go to SETUP.
  - Changes to ctrl_i while busy are ignored.
- SETUP: cs_n_o=0, sclk_o=0. On the first cycle, load the shift register from buf_rdata_i[7:0] and drive mosi_o with bit 7. Stay one half-period, then go to XFER.
- XFER: 16 half-periods.
  - Odd ticks: sclk_o rises; sample the synchronised miso into rx[0], shifting left.
  - Even ticks: sclk_o falls; shift TX so mosi_o presents the next bit.
  - After the 16th tick (sclk_o low): pulse buf_wr_o for 1 cycle with buf_wdata_o={24'b0,rx} at buf_addr_o=idx.
  - If idx==n_tx_end, go to HOLD. Otherwise go to NEXT.
- NEXT (1 cycle): idx+1, buf_addr_o=idx+1. On the following cycle, load the shift register from buf_rdata_i[7:0], drive mosi_o with bit 7, and re-enter XFER without a CS gap (keeps the ALS 16-clock frame contiguous).
- HOLD: sclk_o=0, cs_n_o stays low for one half-period, then cs_n_o=1 and go to WRBACK.
- WRBACK (1 cycle): ctrl_wr_o=1, ctrl_data_o = shadow with [0]=0 and [25:16]=n_tx_end+1. Then go to IDLE.
  - The register gives wr2 priority, so a simultaneous external write loses; this is by design.
  - Clearing send prevents a retrigger.
- Latency per byte is 16*CLK_DIV cycles (plus 1 cycle for NEXT).
- Total burst = CLK_DIV + (n+1)*16*CLK_DIV + n + CLK_DIV + 1 cycles, for n = n_tx_end.
- Boundaries:
  - n_tx_end=0: single byte.
  - n_tx_end=511: idx reaches 511 without wrap, and n_rx=512 fits in 10 bits.
  - send already 0 at IDLE: no action.

Decomposition:
- Package spi_als_pkg holds:
  - the state enum (IDLE, SETUP, XFER, NEXT, HOLD, WRBACK);
  - field position constants CTRL_SEND=0, CTRL_NTX_LSB=4, CTRL_NTX_MSB=12, CTRL_NRX_LSB=16, CTRL_NRX_MSB=25.
- One sub-module, module_spi_shift8: an 8-bit TX/RX shift register with load, shift-on-rise/shift-on-fall strobes, mosi and rx outputs.
- The clock divider stays inline.

Test Plan:
- Reset mid-burst: assert rst_n_i at cycle 40 of a transfer -> cs_n_o=1 and sclk_o=0 in the same cycle, no ctrl_wr_o, busy_o=0.
- Single byte: ctrl_i=0x0000_0001, buf[0]=0xA5, miso loopback from mosi -> exactly 8 SCLK rising edges, mosi sequence 1,0,1,0,0,1,0,1, buf[0] written 0x000000A5, then ctrl_data_o=0x0001_0000 with ctrl_wr_o high for 1 cycle; total 2*5+80+1 = 91 cycles.
- ALS frame: n_tx_end=1, miso model drives 0x0F then 0xF0 -> 16 contiguous SCLKs, cs_n_o low throughout with no gap, buf[0]=0x0F, buf[1]=0xF0, n_rx=2.
- Pass-through: ctrl_i=0xFC00_E00F (n_tx_end=0, reserved bits set) -> write-back 0xFC01_E00E.
- Ignore changes while busy: external ctrl_i change to n_tx_end=5 during an n_tx_end=0 burst -> only 1 byte sent, n_rx=1.
- Max burst: n_tx_end=511, CLK_DIV=2 -> 512 buffer writes at addresses 0..511, n_rx field=0x200, no address wrap.
